// File: rtl/cardinal_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// cardinal_dmem_arbiter
//
// Shares one 256x64 data-memory port between the four Cardinal node cores.
// Round-robin arbitration with an optional bounded lock, so a node can run a
// read-modify-write sequence without another node getting in between.
// Read data returns one cycle after the grant, tagged to the node that issued
// the read.
//
// Optional build macro: CARDINAL_DMEM_ARB_PERF_EN
//   defined   -> four saturating 32-bit grant counters on perf_gnt_cnt
//   undefined -> no counter flops, perf_gnt_cnt tied to 0
//
// Ports (bit i / slice i of every per-node vector belongs to node i):
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   req          in   [0:3]   access request
//   wr           in   [0:3]   1 = write, 0 = read
//   lock         in   [0:3]   lock request, meaningful only with req
//   addr         in   [0:31]  packed addresses, node i at [8i +: 8]
//   wdata        in   [0:255] packed write data, node i at [64i +: 64]
//   gnt          out  [0:3]   one-hot grant (combinational)
//   rvalid       out  [0:3]   one-hot read-return strobe
//   rdata        out  [0:63]  read data broadcast, qualified by rvalid
//   mem_en       out          dmem enable
//   mem_wr_en    out          dmem write enable
//   mem_addr     out  [0:7]   dmem address
//   mem_din      out  [0:63]  dmem write data
//   mem_dout     in   [0:63]  dmem read data, valid the cycle after issue
//   perf_gnt_cnt out  [0:127] packed grant counters, node i at [32i +: 32]
// ---------------------------------------------------------------------------
module cardinal_dmem_arbiter #(
  parameter int NREQ     = 4,
  parameter int AW       = 8,
  parameter int DW       = 64,
  parameter int LOCK_MAX = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [0:NREQ-1]      req,
  input  logic [0:NREQ-1]      wr,
  input  logic [0:NREQ-1]      lock,
  input  logic [0:NREQ*AW-1]   addr,
  input  logic [0:NREQ*DW-1]   wdata,
  output logic [0:NREQ-1]      gnt,
  output logic [0:NREQ-1]      rvalid,
  output logic [0:DW-1]        rdata,
  output logic                 mem_en,
  output logic                 mem_wr_en,
  output logic [0:AW-1]        mem_addr,
  output logic [0:DW-1]        mem_din,
  input  logic [0:DW-1]        mem_dout,
  output logic [0:NREQ*32-1]   perf_gnt_cnt
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          tag_valid_q, tag_valid_d;
  logic [IW-1:0] tag_id_q, tag_id_d;

  logic          rr_vld_s;
  logic [IW-1:0] rr_win_s;
  logic [IW-1:0] scan_idx_s;
  logic          win_vld_s;
  logic [IW-1:0] win_s;
  logic          grant_s;

  // Round-robin pick: first asserted req at or after rr_ptr, wrapping.
  always_comb begin
    rr_vld_s   = 1'b0;
    rr_win_s   = '0;
    scan_idx_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx_s = rr_ptr_q + IW'(k);
      if (!rr_vld_s && req[scan_idx_s]) begin
        rr_vld_s = 1'b1;
        rr_win_s = scan_idx_s;
      end else begin
        rr_vld_s = rr_vld_s;
      end
    end
  end

  // Arbitration FSM: next state, winner and lock bookkeeping.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    win_vld_s  = 1'b0;
    win_s      = '0;
    case (state_q)
      ST_IDLE: begin
        if (rr_vld_s) begin
          win_vld_s = 1'b1;
          win_s     = rr_win_s;
          rr_ptr_d  = rr_win_s + IW'(1);
          if (lock[rr_win_s]) begin
            state_d    = ST_LOCKED;
            owner_d    = rr_win_s;
            lock_cnt_d = CW'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (req[owner_q]) begin
          win_vld_s  = 1'b1;
          win_s      = owner_q;
          lock_cnt_d = lock_cnt_q + CW'(1);
          // The grant that brings the count to LOCK_MAX is still served,
          // then the lock is dropped even if the owner keeps asking.
          if (!lock[owner_q] || (lock_cnt_q == CW'(LOCK_MAX - 1))) begin
            state_d    = ST_IDLE;
            lock_cnt_d = '0;
          end else begin
            state_d = ST_LOCKED;
          end
        end else begin
          state_d    = ST_IDLE;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Reset forces every combinational output quiet during the reset cycle.
  assign grant_s     = win_vld_s & ~reset;
  assign tag_valid_d = grant_s & ~wr[win_s];
  assign tag_id_d    = win_s;

  // Memory-port mux and one-hot grant from the winner.
  always_comb begin
    gnt       = '0;
    mem_en    = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    if (grant_s) begin
      gnt[win_s] = 1'b1;
      mem_en     = 1'b1;
      mem_wr_en  = wr[win_s];
      mem_addr   = addr[int'(win_s)*AW +: AW];
      mem_din    = wdata[int'(win_s)*DW +: DW];
    end else begin
      gnt = '0;
    end
  end

  // Read return: strobe the tagged node, pass dmem data straight through.
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (tag_valid_q && !reset) begin
      rvalid[tag_id_q] = 1'b1;
      rdata            = mem_dout;
    end else begin
      rdata = '0;
    end
  end

  // Arbiter state and read-tag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      lock_cnt_q  <= '0;
      tag_valid_q <= 1'b0;
      tag_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      lock_cnt_q  <= lock_cnt_d;
      tag_valid_q <= tag_valid_d;
      tag_id_q    <= tag_id_d;
    end
  end

`ifdef CARDINAL_DMEM_ARB_PERF_EN
  logic [31:0] perf_cnt_q [NREQ];

  // Saturating per-node grant counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) begin
        perf_cnt_q[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i] && (perf_cnt_q[i] != 32'hFFFF_FFFF)) begin
          perf_cnt_q[i] <= perf_cnt_q[i] + 32'd1;
        end else begin
          perf_cnt_q[i] <= perf_cnt_q[i];
        end
      end
    end
  end

  // Pack counters; held at zero while reset is asserted.
  always_comb begin
    perf_gnt_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!reset) begin
        perf_gnt_cnt[i*32 +: 32] = perf_cnt_q[i];
      end else begin
        perf_gnt_cnt[i*32 +: 32] = 32'd0;
      end
    end
  end
`else
  assign perf_gnt_cnt = '0;
`endif

endmodule

// File: tb/tb_cardinal_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// Self-checking bench for cardinal_dmem_arbiter. A small dmem lives in the
// bench; expected grants, memory-port values, read returns and counters come
// from a transaction-level reference model driven by the same request table.
// ---------------------------------------------------------------------------
module tb_cardinal_dmem_arbiter;

  logic          clk;
  logic          reset;
  logic [0:3]    req_v, wr_v, lock_v;
  logic [0:31]   addr_v;
  logic [0:255]  wdata_v;
  logic [0:3]    gnt, rvalid;
  logic [0:63]   rdata;
  logic          mem_en, mem_wr_en;
  logic [0:7]    mem_addr;
  logic [0:63]   mem_din;
  logic [0:63]   mem_dout_q;
  logic [0:127]  perf_gnt_cnt;

  cardinal_dmem_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req_v),
    .wr           (wr_v),
    .lock         (lock_v),
    .addr         (addr_v),
    .wdata        (wdata_v),
    .gnt          (gnt),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .mem_en       (mem_en),
    .mem_wr_en    (mem_wr_en),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout_q),
    .perf_gnt_cnt (perf_gnt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench dmem: synchronous write, registered read, backdoor preload port.
  logic [63:0] dmem [256];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [63:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) dmem[pl_addr] <= pl_data;
    else if (mem_en) begin
      if (mem_wr_en) dmem[mem_addr] <= mem_din;
      else mem_dout_q <= dmem[mem_addr];
    end
  end

  // Per-node pending requests (held until granted).
  bit          p_req [4];
  bit          p_wr  [4];
  bit          p_lock[4];
  logic [7:0]  p_addr[4];
  logic [63:0] p_wdata[4];

  // Reference model state.
  logic [63:0] shadow [256];
  int          m_next;       // node that has first claim in the next free arbitration
  int          m_owner;      // lock holder, -1 when unlocked
  int          m_held;       // grants taken under the current lock
  int          m_rv;         // node expecting read data next cycle, -1 none
  logic [63:0] m_rdata;
  logic [31:0] m_cnt [4];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int n = 0; n < 4; n++) begin
      req_v[n]              = p_req[n];
      wr_v[n]               = p_wr[n];
      lock_v[n]             = p_lock[n];
      addr_v[8*n +: 8]      = p_addr[n];
      wdata_v[64*n +: 64]   = p_wdata[n];
    end
  endtask

  task automatic model_reset();
    m_next = 0; m_owner = -1; m_held = 0; m_rv = -1; m_rdata = 64'd0;
    for (int n = 0; n < 4; n++) m_cnt[n] = 32'd0;
  endtask

  // One clock cycle: drive, check mid-cycle against the model, advance model.
  // tp_win: -2 no directed check, -1 expect no grant, else expected node.
  task automatic cycle(input bit rst, input int tp_win);
    int          win;
    logic [0:3]  e_gnt, e_rv, e_tp;
    logic [7:0]  e_addr;
    logic [63:0] e_din, e_rd;
    logic [31:0] e_pc;
    bit          e_wr;
    reset = rst;
    drive();
    #3;
    win = -1;
    if (!rst) begin
      if (m_owner < 0) begin
        for (int k = 0; k < 4; k++) begin
          int n;
          n = (m_next + k) % 4;
          if (win < 0 && p_req[n]) win = n;
        end
      end else if (p_req[m_owner]) win = m_owner;
    end
    e_gnt = '0; e_addr = 8'd0; e_din = 64'd0; e_wr = 1'b0;
    if (win >= 0) begin
      e_gnt[win] = 1'b1; e_addr = p_addr[win]; e_din = p_wdata[win]; e_wr = p_wr[win];
    end
    e_rv = '0; e_rd = 64'd0;
    if (!rst && m_rv >= 0) begin
      e_rv[m_rv] = 1'b1; e_rd = m_rdata;
    end
    chk("gnt", gnt, e_gnt);
    chk("mem_en", mem_en, (win >= 0));
    chk("mem_wr_en", mem_wr_en, e_wr);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_din", mem_din, e_din);
    chk("rvalid", rvalid, e_rv);
    chk("rdata", rdata, e_rd);
    for (int n = 0; n < 4; n++) begin
`ifdef CARDINAL_DMEM_ARB_PERF_EN
      e_pc = rst ? 32'd0 : m_cnt[n];
`else
      e_pc = 32'd0;
`endif
      chk("perf_cnt", perf_gnt_cnt[32*n +: 32], e_pc);
    end
    if (tp_win >= -1) begin
      e_tp = '0;
      if (tp_win >= 0) e_tp[tp_win] = 1'b1;
      chk("tp_gnt", gnt, e_tp);
    end
    @(posedge clk);
    if (rst) model_reset();
    else begin
      m_rv = -1;
      if (win >= 0) begin
        if (m_cnt[win] != 32'hFFFF_FFFF) m_cnt[win] = m_cnt[win] + 32'd1;
        if (p_wr[win]) shadow[p_addr[win]] = p_wdata[win];
        else begin
          m_rv    = win;
          m_rdata = shadow[p_addr[win]];
        end
        if (m_owner < 0) begin
          m_next = (win + 1) % 4;
          if (p_lock[win]) begin m_owner = win; m_held = 1; end
        end else begin
          m_held++;
          if (!p_lock[win] || m_held >= 16) m_owner = -1;
        end
        p_req[win] = 1'b0;
      end else if (m_owner >= 0) m_owner = -1;
    end
    #1;
  endtask

  task automatic clear_reqs();
    for (int n = 0; n < 4; n++) begin
      p_req[n] = 1'b0; p_wr[n] = 1'b0; p_lock[n] = 1'b0;
    end
  endtask

  initial begin
    for (int n = 0; n < 4; n++) begin
      p_req[n] = 1'b0; p_wr[n] = 1'b0; p_lock[n] = 1'b0;
      p_addr[n] = 8'd0; p_wdata[n] = 64'd0;
    end
    reset = 1'b1; pl_en = 1'b0; pl_addr = 8'd0; pl_data = 64'd0;
    drive();
    model_reset();

    // Preload dmem and the shadow copy while the arbiter is held in reset.
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) begin
      pl_en   = 1'b1;
      pl_addr = 8'(i);
      pl_data = (i == 5) ? 64'h0000_0000_DEAD_BEEF : {$urandom, $urandom};
      shadow[i] = pl_data;
      @(posedge clk); #1;
    end
    pl_en = 1'b0;

    // Reset state.
    cycle(1'b1, -1);
    cycle(1'b0, -1);

    // Single read from node 2 at 0x05.
    p_req[2] = 1'b1; p_wr[2] = 1'b0; p_addr[2] = 8'h05;
    cycle(1'b0, 2);
    #3;
    chk("tp_single_rvalid", rvalid, 4'b0010);
    chk("tp_single_rdata", rdata, 64'h0000_0000_DEAD_BEEF);
    cycle(1'b0, -1);

    // All four nodes read continuously from reset: 0,1,2,3,0.
    cycle(1'b1, -1);
    for (int j = 0; j < 5; j++) begin
      for (int n = 0; n < 4; n++) begin
        p_req[n] = 1'b1; p_wr[n] = 1'b0; p_addr[n] = 8'($urandom_range(0, 255));
      end
      cycle(1'b0, j % 4);
    end
    clear_reqs();
    cycle(1'b0, -1);

    // Node 1 writes 0x10, node 3 reads it back next cycle.
    p_req[1] = 1'b1; p_wr[1] = 1'b1; p_addr[1] = 8'h10; p_wdata[1] = 64'h1122_3344_5566_7788;
    cycle(1'b0, 1);
    p_req[3] = 1'b1; p_wr[3] = 1'b0; p_addr[3] = 8'h10;
    cycle(1'b0, 3);
    #3;
    chk("tp_raw_rvalid", rvalid, 4'b0001);
    chk("tp_raw_rdata", rdata, 64'h1122_3344_5566_7788);
    cycle(1'b0, -1);

    // Locked sequence: node 0 holds lock for three accesses, others wait.
    cycle(1'b1, -1);
    for (int j = 0; j < 3; j++) begin
      for (int n = 0; n < 4; n++) begin
        p_req[n] = 1'b1; p_wr[n] = 1'b0; p_addr[n] = 8'(n + 32);
        p_lock[n] = 1'b0;
      end
      p_lock[0] = (j < 2);
      cycle(1'b0, 0);
    end
    p_lock[0] = 1'b0;
    for (int n = 1; n < 4; n++) p_req[n] = 1'b1;
    cycle(1'b0, 1);
    clear_reqs();
    cycle(1'b0, -2);

    // Lock timeout: node 0 locks for 20 cycles, node 1 waits.
    cycle(1'b1, -1);
    for (int j = 1; j <= 20; j++) begin
      p_req[0] = 1'b1; p_lock[0] = 1'b1; p_wr[0] = 1'b1; p_addr[0] = 8'h40; p_wdata[0] = 64'(j);
      p_req[1] = 1'b1; p_wr[1] = 1'b0; p_addr[1] = 8'h40;
      cycle(1'b0, (j <= 16) ? 0 : ((j == 17) ? 1 : -2));
    end
    clear_reqs();
    cycle(1'b0, -2);
    cycle(1'b0, -1);

    // Five reads by node 0, then reset while the last read is in flight.
    cycle(1'b1, -1);
    for (int j = 0; j < 5; j++) begin
      p_req[0] = 1'b1; p_wr[0] = 1'b0; p_addr[0] = 8'(j);
      cycle(1'b0, 0);
    end
    p_req[0] = 1'b1;
    cycle(1'b1, -1);
    clear_reqs();
    cycle(1'b0, -1);
    #3;
    chk("tp_rst_rvalid", rvalid, 4'b0000);
    chk("tp_rst_perf", perf_gnt_cnt, 128'd0);
    cycle(1'b0, -1);

    // Randomized traffic with holds, withdrawals, locks and occasional reset.
    cycle(1'b1, -1);
    for (int it = 0; it < 800; it++) begin
      bit rst;
      for (int n = 0; n < 4; n++) begin
        if (!p_req[n]) begin
          if ((n == m_owner) || ($urandom_range(0, 1) == 1)) begin
            p_req[n]   = 1'b1;
            p_wr[n]    = ($urandom_range(0, 2) == 0);
            p_addr[n]  = 8'($urandom_range(0, 15));
            p_wdata[n] = {$urandom, $urandom};
            p_lock[n]  = (n == m_owner) ? ($urandom_range(0, 7) != 0)
                                        : ($urandom_range(0, 5) == 0);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          p_req[n] = 1'b0;
        end
      end
      rst = ($urandom_range(0, 99) == 0);
      cycle(rst, -2);
    end
    clear_reqs();
    cycle(1'b0, -2);
    cycle(1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
